ascensor_planta: RTL and testbench
==================================

# ascensor_planta

Synthesizable plant model of the elevator car and doors: the responding end of the controller interface. It consumes the controller's `motor` and `puertas` commands and produces the `cambio_piso`, `estado_puertas` and `sensor_puertas` feedback the controller expects, with configurable travel and door timing. It sits between the elevator controller and the test bench, closing the loop so the controller runs against realistic, cycle-accurate mechanics.

## Interface
- `NUM_PISOS`, default 10: number of floors, 2..16.
- `TRAVEL_CYCLES`, default 100: clock cycles to travel one floor, ≥2.
- `DOOR_CYCLES`, default 50: clock cycles for a full door open or close stroke, ≥2.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `motor`  in  2  controller command: 00 stop, 01 up, 10 down, 11 illegal.
- `puertas`  in  2  controller command: 00 hold, 01 open, 10 close, 11 illegal.
- `obstruccion`  in  1  bench-injected physical obstruction in the doorway.
- `cambio_piso`  out  1  one-cycle pulse per floor reached.
- `estado_puertas`  out  2  00 closed, 01 moving, 10 open, 11 unused (never driven).
- `sensor_puertas`  out  1  door obstruction sensor, registered.
- `piso`  out  4  current floor, 0..NUM_PISOS-1, for checking.
- `falla`  out  1  sticky plant-violation flag.

## Operation
- Door FSM states: CERRADA, ABRIENDO, ABIERTA, CERRANDO; `estado_puertas` = 00 / 01 / 10 / 01 respectively.
- CERRADA + `puertas`=01 → ABRIENDO, door counter loaded with 0.
- ABRIENDO: counter increments each cycle; at DOOR_CYCLES-1 → ABIERTA. `puertas`=10 here is ignored.
- ABIERTA + `puertas`=10 → CERRANDO, counter 0.
- CERRANDO: counter increments; at DOOR_CYCLES-1 → CERRADA. `obstruccion`=1 or `puertas`=01 in CERRANDO → ABRIENDO, counter 0 (full reopen stroke). Obstruction has priority over completion in the same cycle.
- `sensor_puertas` = registered (`obstruccion` AND door state ≠ CERRADA).
- Car motion only when door state is CERRADA and `motor` ∈ {01, 10}:
  - travel counter increments each such cycle; on reaching TRAVEL_CYCLES-1, `piso` ±1, counter 0, `cambio_piso` pulsed.
  - `motor`=00, `motor`=11, or a direction change clears the travel counter (car snaps to current floor).
  - up at `piso`=NUM_PISOS-1 or down at `piso`=0: no motion, counter held at 0.
  - motion command while door ≠ CERRADA: no motion, counter cleared.
- `falla` set (sticky until reset) on any of: `motor`=11; `puertas`=11; `motor`≠00 while door ≠ CERRADA; overrun attempt at either end floor; `puertas`=01 while travel counter ≠ 0.
- Illegal `puertas`=11 is treated as hold.

## Timing
- Reset values: `piso`=0, door CERRADA, `estado_puertas`=00, `cambio_piso`=0, `sensor_puertas`=0, `falla`=0, both counters 0.
- All outputs are registered; inputs are sampled at rising edge.
- Door: `puertas`=01 sampled at edge N → `estado_puertas`=01 after edge N, =10 after edge N+DOOR_CYCLES.
- Travel: `motor`=01 sampled at edges N..N+TRAVEL_CYCLES-1 → `piso` updated and `cambio_piso`=1 after edge N+TRAVEL_CYCLES-1, for exactly one cycle.
- Obstruction: `obstruccion` at edge N → `sensor_puertas` after edge N; door reverses to ABRIENDO after the same edge.
- Reset mid-stroke or mid-travel: all state returns to reset values on the next edge; no `cambio_piso` pulse is emitted.

## Configuration
- `ASCENSOR_PLANTA_CHECK_EN` defined: `falla` logic compiled in as described.
- Not defined: `falla` tied to 0 and no check logic is generated. Motion blocking, end-floor clamping, and illegal-code-as-stop/hold behaviour remain unchanged.

## Test plan
- Reset, then `motor`=01 held with TRAVEL_CYCLES=100 → `cambio_piso` pulses at cycles 100, 200, 300; `piso` goes 1, 2, 3; `falla`=0.
- `puertas`=01 one cycle from CERRADA, DOOR_CYCLES=50 → `estado_puertas`=01 for 50 cycles, then 10; `puertas`=10 → 01 for 50 cycles, then 00.
- During CERRANDO at counter 30, `obstruccion`=1 → `sensor_puertas`=1 the next cycle, door ABRIENDO, `estado_puertas`=10 50 cycles later.
- `motor`=10 at `piso`=0 → `piso` stays 0, no pulse, `falla`=1 (CHECK_EN); `falla`=0 with the macro undefined.
- Door ABIERTA plus `motor`=01 for 200 cycles → `piso` unchanged, no `cambio_piso`, `falla`=1.
- `motor`=01 for 60 cycles, then `reset` for 1 cycle, then `motor`=01 → first pulse 100 cycles after reset release, `piso`=1.

Source files
------------

// File: rtl/ascensor_planta_if.sv
// Controller-facing bus of the elevator plant model: motor/door commands in, car and door feedback out.
// The master side is the controller (or the bench standing in for it); the plant is the slave.
interface ascensor_planta_if;
    logic [1:0] motor;
    logic [1:0] puertas;
    logic       obstruccion;
    logic       cambio_piso;
    logic [1:0] estado_puertas;
    logic       sensor_puertas;
    logic [3:0] piso;
    logic       falla;

    modport master (
        output motor, puertas, obstruccion,
        input  cambio_piso, estado_puertas, sensor_puertas, piso, falla
    );

    modport slave (
        input  motor, puertas, obstruccion,
        output cambio_piso, estado_puertas, sensor_puertas, piso, falla
    );
endinterface

// File: rtl/ascensor_planta.sv
// Cycle-accurate plant model of the elevator car and doors with configurable travel and door timing.
// Define ASCENSOR_PLANTA_CHECK_EN to build the sticky falla checker; otherwise falla is tied low.
module ascensor_planta #(
    parameter int NUM_PISOS     = 10,
    parameter int TRAVEL_CYCLES = 100,
    parameter int DOOR_CYCLES   = 50
) (
    input logic              clk,
    input logic              reset,
    ascensor_planta_if.slave bus
);
    localparam int TW = (TRAVEL_CYCLES > 2) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 2) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TW-1:0] TRAV_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_CYCLES - 1);
    localparam logic [3:0]    PISO_TOP  = 4'(NUM_PISOS - 1);

    localparam logic [1:0] CERRADA  = 2'd0;
    localparam logic [1:0] ABRIENDO = 2'd1;
    localparam logic [1:0] ABIERTA  = 2'd2;
    localparam logic [1:0] CERRANDO = 2'd3;

    logic [1:0]    door, door_next;
    logic [DW-1:0] door_cnt, door_cnt_next;
    logic [1:0]    estado;
    logic          sensor;
    logic [TW-1:0] trav_cnt, trav_next;
    logic [1:0]    dir, dir_next;
    logic [3:0]    piso_q, piso_next;
    logic          pulso, pulso_next;
    logic          sube, baja, cerrada, tope;

    function automatic logic [1:0] codigo_puertas(input logic [1:0] s);
        case (s)
            CERRADA: codigo_puertas = 2'b00;
            ABIERTA: codigo_puertas = 2'b10;
            default: codigo_puertas = 2'b01;
        endcase
    endfunction

    assign sube    = (bus.motor == 2'b01);
    assign baja    = (bus.motor == 2'b10);
    assign cerrada = (door == CERRADA);
    assign tope    = (sube && piso_q == PISO_TOP) || (baja && piso_q == 4'd0);

    always_comb begin
        door_next     = door;
        door_cnt_next = door_cnt;
        case (door)
            CERRADA: begin
                if (bus.puertas == 2'b01) begin
                    door_next     = ABRIENDO;
                    door_cnt_next = '0;
                end
            end
            ABRIENDO: begin
                if (door_cnt == DOOR_LAST) begin
                    door_next     = ABIERTA;
                    door_cnt_next = '0;
                end else begin
                    door_cnt_next = door_cnt + DW'(1);
                end
            end
            ABIERTA: begin
                if (bus.puertas == 2'b10) begin
                    door_next     = CERRANDO;
                    door_cnt_next = '0;
                end
            end
            default: begin
                // A reopen request or obstruction wins over stroke completion in the same cycle
                if (bus.obstruccion || bus.puertas == 2'b01) begin
                    door_next     = ABRIENDO;
                    door_cnt_next = '0;
                end else if (door_cnt == DOOR_LAST) begin
                    door_next     = CERRADA;
                    door_cnt_next = '0;
                end else begin
                    door_cnt_next = door_cnt + DW'(1);
                end
            end
        endcase
    end

    always_comb begin
        trav_next  = trav_cnt;
        dir_next   = dir;
        piso_next  = piso_q;
        pulso_next = 1'b0;
        if (!cerrada || !(sube || baja) || tope) begin
            trav_next = '0;
        end else if (trav_cnt != '0 && bus.motor != dir) begin
            // Reversal mid-floor snaps the car back to its current floor
            trav_next = '0;
            dir_next  = bus.motor;
        end else if (trav_cnt == TRAV_LAST) begin
            trav_next  = '0;
            dir_next   = bus.motor;
            piso_next  = sube ? piso_q + 4'd1 : piso_q - 4'd1;
            pulso_next = 1'b1;
        end else begin
            trav_next = trav_cnt + TW'(1);
            dir_next  = bus.motor;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            door     <= CERRADA;
            door_cnt <= '0;
            estado   <= 2'b00;
            sensor   <= 1'b0;
            trav_cnt <= '0;
            dir      <= 2'b00;
            piso_q   <= 4'd0;
            pulso    <= 1'b0;
        end else begin
            door     <= door_next;
            door_cnt <= door_cnt_next;
            estado   <= codigo_puertas(door_next);
            sensor   <= bus.obstruccion && !cerrada;
            trav_cnt <= trav_next;
            dir      <= dir_next;
            piso_q   <= piso_next;
            pulso    <= pulso_next;
        end
    end

    assign bus.cambio_piso    = pulso;
    assign bus.estado_puertas = estado;
    assign bus.sensor_puertas = sensor;
    assign bus.piso           = piso_q;

`ifdef ASCENSOR_PLANTA_CHECK_EN
    logic falla_q, viola;

    assign viola = (bus.motor == 2'b11) || (bus.puertas == 2'b11)
                || (bus.motor != 2'b00 && !cerrada) || tope
                || (bus.puertas == 2'b01 && trav_cnt != '0);

    always_ff @(posedge clk) begin
        if (reset) falla_q <= 1'b0;
        else if (viola) falla_q <= 1'b1;
    end

    assign bus.falla = falla_q;
`else
    assign bus.falla = 1'b0;
`endif
endmodule

// File: tb/tb_ascensor_planta.sv
// Bench for ascensor_planta: floor-arrival pulses are checked against a scoreboard of expected (cycle, floor) events.
// Door, obstruction, end-floor and reset scenarios are checked inline by their own tasks.
module tb_ascensor_planta;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   ecnt = 0;
    int   tests = 0;
    int   fails = 0;

`ifdef ASCENSOR_PLANTA_CHECK_EN
    localparam logic EXP_FALLA = 1'b1;
`else
    localparam logic EXP_FALLA = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [3:0] piso;
    } ev_t;
    ev_t sb[$];

    ascensor_planta_if bus ();

    ascensor_planta #(
        .NUM_PISOS(10),
        .TRAVEL_CYCLES(100),
        .DOOR_CYCLES(50)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    // Every cambio_piso pulse must match the oldest expected arrival
    always @(negedge clk) begin
        if (bus.cambio_piso === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse: cambio_piso=1 at edge %0d piso=%0d, required no pulse", ecnt, bus.piso);
            end else begin
                ev_t e;
                e = sb.pop_front();
                if (ecnt !== e.cyc || bus.piso !== e.piso) begin
                    fails++;
                    $display("FAIL pulse: edge %0d piso %0d, required edge %0d piso %0d", ecnt, bus.piso, e.cyc, e.piso);
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        bus.motor = 2'b00;
        bus.puertas = 2'b00;
        bus.obstruccion = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic open_door();
        bus.puertas = 2'b01;
        @(negedge clk);
        bus.puertas = 2'b00;
        repeat (50) @(negedge clk);
    endtask

    task automatic close_door();
        bus.puertas = 2'b10;
        @(negedge clk);
        bus.puertas = 2'b00;
        repeat (50) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        do_reset();
        tests++;
        if (bus.piso !== 4'd0 || bus.estado_puertas !== 2'b00 || bus.cambio_piso !== 1'b0
            || bus.sensor_puertas !== 1'b0 || bus.falla !== 1'b0) begin
            fails++;
            $display("FAIL reset: piso=%0d estado=%b cambio=%b sensor=%b falla=%b, required 0 00 0 0 0",
                     bus.piso, bus.estado_puertas, bus.cambio_piso, bus.sensor_puertas, bus.falla);
        end
    endtask

    task automatic test_travel();
        int t0;
        t0 = ecnt;
        for (int k = 1; k <= 3; k++) sb.push_back('{t0 + 100 * k, 4'(k)});
        bus.motor = 2'b01;
        repeat (300) @(negedge clk);
        bus.motor = 2'b00;
        repeat (5) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL travel_pending: %0d pulses missing, required 0", sb.size());
            sb.delete();
        end
        tests++;
        if (bus.piso !== 4'd3 || bus.falla !== 1'b0) begin
            fails++;
            $display("FAIL travel_final: piso=%0d falla=%b, required 3 0", bus.piso, bus.falla);
        end
    endtask

    task automatic test_doors();
        logic [1:0] exp;
        bus.puertas = 2'b01;
        for (int i = 1; i <= 51; i++) begin
            @(negedge clk);
            bus.puertas = 2'b00;
            exp = (i <= 50) ? 2'b01 : 2'b10;
            tests++;
            if (bus.estado_puertas !== exp) begin
                fails++;
                $display("FAIL door_open[%0d]: estado=%b, required %b", i, bus.estado_puertas, exp);
            end
        end
        bus.puertas = 2'b10;
        for (int i = 1; i <= 51; i++) begin
            @(negedge clk);
            bus.puertas = 2'b00;
            exp = (i <= 50) ? 2'b01 : 2'b00;
            tests++;
            if (bus.estado_puertas !== exp) begin
                fails++;
                $display("FAIL door_close[%0d]: estado=%b, required %b", i, bus.estado_puertas, exp);
            end
        end
        tests++;
        if (bus.falla !== 1'b0 || bus.sensor_puertas !== 1'b0) begin
            fails++;
            $display("FAIL door_flags: falla=%b sensor=%b, required 0 0", bus.falla, bus.sensor_puertas);
        end
    endtask

    task automatic test_obstruction();
        logic [1:0] exp;
        open_door();
        bus.puertas = 2'b10;
        @(negedge clk);
        bus.puertas = 2'b00;
        repeat (30) @(negedge clk);
        bus.obstruccion = 1'b1;
        @(negedge clk);
        bus.obstruccion = 1'b0;
        tests++;
        if (bus.sensor_puertas !== 1'b1 || bus.estado_puertas !== 2'b01) begin
            fails++;
            $display("FAIL obstruction: sensor=%b estado=%b, required 1 01", bus.sensor_puertas, bus.estado_puertas);
        end
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            exp = (i < 50) ? 2'b01 : 2'b10;
            tests++;
            if (bus.estado_puertas !== exp || (i == 1 && bus.sensor_puertas !== 1'b0)) begin
                fails++;
                $display("FAIL reopen[%0d]: estado=%b sensor=%b, required %b", i, bus.estado_puertas, bus.sensor_puertas, exp);
            end
        end
        close_door();
        tests++;
        if (bus.estado_puertas !== 2'b00) begin
            fails++;
            $display("FAIL reclose: estado=%b, required 00", bus.estado_puertas);
        end
    endtask

    task automatic test_motion_door_open();
        open_door();
        bus.motor = 2'b01;
        repeat (200) @(negedge clk);
        bus.motor = 2'b00;
        tests++;
        if (bus.piso !== 4'd3 || bus.falla !== EXP_FALLA) begin
            fails++;
            $display("FAIL motion_door_open: piso=%0d falla=%b, required 3 %b", bus.piso, bus.falla, EXP_FALLA);
        end
        close_door();
    endtask

    task automatic test_overrun_bottom();
        do_reset();
        bus.motor = 2'b10;
        repeat (150) @(negedge clk);
        bus.motor = 2'b00;
        @(negedge clk);
        tests++;
        if (bus.piso !== 4'd0 || bus.falla !== EXP_FALLA) begin
            fails++;
            $display("FAIL overrun_bottom: piso=%0d falla=%b, required 0 %b", bus.piso, bus.falla, EXP_FALLA);
        end
    endtask

    task automatic test_reset_mid_travel();
        do_reset();
        bus.motor = 2'b01;
        repeat (60) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++;
        if (bus.piso !== 4'd0 || bus.cambio_piso !== 1'b0 || bus.falla !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: piso=%0d cambio=%b falla=%b, required 0 0 0", bus.piso, bus.cambio_piso, bus.falla);
        end
        sb.push_back('{ecnt + 100, 4'd1});
        repeat (100) @(negedge clk);
        bus.motor = 2'b00;
        repeat (5) @(negedge clk);
        tests++;
        if (sb.size() != 0 || bus.piso !== 4'd1) begin
            fails++;
            $display("FAIL mid_reset_travel: pending=%0d piso=%0d, required 0 1", sb.size(), bus.piso);
            sb.delete();
        end
    endtask

    initial begin
        bus.motor = 2'b00;
        bus.puertas = 2'b00;
        bus.obstruccion = 1'b0;
        test_reset();
        test_travel();
        test_doors();
        test_obstruction();
        test_motion_door_open();
        test_overrun_bottom();
        test_reset_mid_travel();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
